op_demux_1x2_32bit: RTL and testbench
=====================================

Name: op_demux_1x2_32bit

Overview:
- 1-to-2 demultiplexer that routes 32-bit operands from the issue stage to one of two execution paths: path 0 is the single-cycle carry-lookahead adder, path 1 is the multi-cycle mod unit.
- Each output has a one-entry registered slot with valid/ready handshake.
- An in-order select FIFO records which path each accepted operand went to.
- The result-side 2:1 mux pops this FIFO, so it can pick results in issue order.

Parameters:
- ORDER_DEPTH, 4, entries in the order FIFO (power of 2, at least 2)
- ORDER_AW, 2, pointer width, equal to log2(ORDER_DEPTH)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  operand accepted this cycle when in_valid is also high
- in_data  input  32  operand word
- in_sel  input  1  0 routes to path 0 (cla), 1 routes to path 1 (mod); only meaningful when in_valid is high
- out0_valid  output  1  slot 0 holds data
- out0_ready  input  1  path 0 consumer ready
- out0_data  output  32  slot 0 contents
- out1_valid  output  1  slot 1 holds data
- out1_ready  input  1  path 1 consumer ready
- out1_data  output  32  slot 1 contents
- order_valid  output  1  order FIFO not empty
- order_sel  output  1  sel value of the oldest unretired operand
- order_pop  input  1  result mux retires the head entry
- order_count  output  ORDER_AW+1  current order FIFO occupancy

Behaviour:
- Reset (synchronous, takes priority over all other activity, including an in-flight handshake):
  - out0_valid, out1_valid, order_valid = 0
  - out0_data, out1_data = 0
  - FIFO pointers = 0, order_count = 0, order_sel = 0
- Handshake definitions:
  - accept = in_valid & in_ready
  - drainN = outN_valid & outN_ready
  - pop = order_pop & order_valid; order_pop while empty is ignored
- in_ready is combinational. It is 1 only when both conditions hold:
  - the selected slot is free: !out[in_sel]_valid, or drain[in_sel] this cycle
  - the FIFO can take an entry: order_count < ORDER_DEPTH, or pop this cycle
- in_ready may depend on in_sel and outN_ready. It must not depend on in_valid.
- Slot N update, in priority order:
  - accept with in_sel = N: slotN_data <= in_data, outN_valid <= 1. This covers a same-cycle drain and load, so back-to-back throughput is 1 word/cycle per path.
  - otherwise drainN: outN_valid <= 0, data held.
  - otherwise: hold.
- The unselected slot is never disturbed by an accept.
- Latency: the operand is visible on outN_data exactly 1 cycle after accept.
- outN_data and outN_valid are stable while outN_valid & !outN_ready. No data is dropped or overwritten before a drain.
- Order FIFO:
  - On accept, push in_sel at the write pointer.
  - On pop, advance the read pointer.
  - Pointers wrap modulo ORDER_DEPTH.
  - Push and pop in the same cycle: count unchanged. This is legal when full (pop frees space) and when empty (pop is then ignored, so count becomes 1).
  - order_sel = mem[rd_ptr], registered storage, read combinationally.
  - When full with no pop, in_ready = 0 regardless of slot state.
- Both paths drain independently. Path 1 can stall (mod busy) while path 0 continues, provided FIFO space remains.
- No internal FSM beyond the per-slot valid bits and FIFO count. Slot states are EMPTY and FULL:
  - EMPTY -> FULL on accept to that slot
  - FULL -> EMPTY on drain without accept
  - FULL -> FULL on drain+accept, or on stall

Test Plan:
- Reset then idle: all outputs 0, order_count 0, in_ready = 1 for both sel values.
- Single route: in_data=0x0000_00A5, sel=0, accepted at cycle T. Required: out0_valid=1 and out0_data=0x0000_00A5 at T+1; out1_valid stays 0; order_sel=0, order_count=1.
- Stall path 1: out1_ready=0, send 0x1111_1111 with sel=1, then 0x2222_2222 with sel=1. Required:
  - second word has in_ready=0 and out1_data holds 0x1111_1111
  - meanwhile 0x3333_3333 with sel=0 is accepted and appears on out0
- Streaming: out0_ready=1, send 8 words sel=0 with order_pop=1 every cycle. Required: 1 word/cycle, in order, order_count never above 1.
- FIFO full: no order_pop, accept 4 words with alternating sel and both outputs ready. Required:
  - order_count=4, and a 5th in_valid gets in_ready=0
  - raising order_pop accepts the 5th word the same cycle, order_count stays 4
  - the head sequence read out is 0,1,0,1,then the 5th word's sel (wrap-around)
- Reset mid-operation: assert reset with both slots full and order_count=3. Required: next cycle all valids 0, order_count 0, data 0, and the handshake on the reset cycle is discarded.

Source files
------------

// File: rtl/op_demux_1x2_32bit.sv
// Routes issue-stage operands to the cla (path 0) or mod (path 1) slot and
// records each routing decision in an in-order select FIFO for the result mux.
//
// slot state | meaning
// EMPTY      | outN_valid = 0, slot can take an operand
// FULL       | outN_valid = 1, operand held until the consumer drains it
module op_demux_1x2_32bit #(
  parameter int ORDER_DEPTH = 4,
  parameter int ORDER_AW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_sel,
  output logic                out0_valid,
  input  logic                out0_ready,
  output logic [31:0]         out0_data,
  output logic                out1_valid,
  input  logic                out1_ready,
  output logic [31:0]         out1_data,
  output logic                order_valid,
  output logic                order_sel,
  input  logic                order_pop,
  output logic [ORDER_AW:0]   order_count
);

  localparam logic [ORDER_AW:0]   CNT_FULL = (ORDER_AW+1)'(ORDER_DEPTH);
  localparam logic [ORDER_AW:0]   CNT_ONE  = (ORDER_AW+1)'(1);
  localparam logic [ORDER_AW-1:0] PTR_ONE  = ORDER_AW'(1);

  logic                   drain0;
  logic                   drain1;
  logic                   pop;
  logic                   accept;
  logic                   load0;
  logic                   load1;
  logic                   slot_free;
  logic                   fifo_room;
  logic [ORDER_DEPTH-1:0] order_mem;
  logic [ORDER_AW-1:0]    wr_ptr;
  logic [ORDER_AW-1:0]    rd_ptr;

  assign drain0      = out0_valid & out0_ready;
  assign drain1      = out1_valid & out1_ready;
  assign order_valid = (order_count != '0);
  assign pop         = order_pop & order_valid;
  assign order_sel   = order_mem[rd_ptr];

  // A draining slot or a popping FIFO frees its space in the same cycle.
  assign slot_free = in_sel ? (~out1_valid | drain1) : (~out0_valid | drain0);
  assign fifo_room = (order_count < CNT_FULL) | pop;
  assign in_ready  = slot_free & fifo_room;

  assign accept = in_valid & in_ready;
  assign load0  = accept & ~in_sel;
  assign load1  = accept & in_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (drain0) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      order_mem   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      order_count <= '0;
    end else begin
      if (accept) begin
        order_mem[wr_ptr] <= in_sel;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept && !pop) begin
        order_count <= order_count + CNT_ONE;
      end else if (!accept && pop) begin
        order_count <= order_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_op_demux_1x2_32bit.sv
// Scoreboard bench for op_demux_1x2_32bit: the driver queues expected words and
// selects on accept, a negedge monitor checks each drain and order pop.
module tb_op_demux_1x2_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic        order_valid;
  logic        order_sel;
  logic        order_pop;
  logic [2:0]  order_count;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int maxc     = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        qo[$];

  always #5 clk = ~clk;

  op_demux_1x2_32bit #(.ORDER_DEPTH(4), .ORDER_AW(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .order_valid(order_valid), .order_sel(order_sel), .order_pop(order_pop),
    .order_count(order_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a drain or pop happens on the next posedge when these hold now.
  always @(negedge clk) begin
    if (!reset) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL out0_unexpected: got %h expected nothing", out0_data);
        end else chk("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL out1_unexpected: got %h expected nothing", out1_data);
        end else chk("out1_data", out1_data, q1.pop_front());
      end
      if (order_pop && order_valid) begin
        if (qo.size() == 0) begin
          checks++; failures++;
          $display("FAIL order_unexpected: got %0d expected nothing", order_sel);
        end else chk("order_sel", {31'd0, order_sel}, {31'd0, qo.pop_front()});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (!reset && in_valid && in_ready) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
      qo.push_back(in_sel);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0; order_pop = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset then idle
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_order_valid", order_valid, 0);
    chk("rst_order_sel", order_sel, 0);
    chk("rst_order_count", order_count, 0);
    drive(0, 0, '0);
    chk("idle_ready_sel0", in_ready, 1);
    drive(0, 1, '0);
    chk("idle_ready_sel1", in_ready, 1);

    // Single route
    drive(1, 0, 32'h0000_00A5);
    step();
    drive(0, 0, '0);
    chk("single_out0_valid", out0_valid, 1);
    chk("single_out0_data", out0_data, 32'h0000_00A5);
    chk("single_out1_valid", out1_valid, 0);
    chk("single_order_sel", order_sel, 0);
    chk("single_order_count", order_count, 1);
    out0_ready = 1'b1; order_pop = 1'b1;
    step();
    out0_ready = 1'b0; order_pop = 1'b0;
    chk("single_drained_count", order_count, 0);

    // Stall path 1 while path 0 proceeds
    drive(1, 1, 32'h1111_1111);
    step();
    drive(1, 1, 32'h2222_2222);
    chk("stall_ready_sel1", in_ready, 0);
    step();
    chk("stall_out1_hold", out1_data, 32'h1111_1111);
    chk("stall_out1_valid", out1_valid, 1);
    drive(1, 0, 32'h3333_3333);
    chk("stall_ready_sel0", in_ready, 1);
    step();
    chk("stall_out0_data", out0_data, 32'h3333_3333);
    chk("stall_order_count", order_count, 2);
    out0_ready = 1'b1; out1_ready = 1'b1; order_pop = 1'b1;
    drive(1, 1, 32'h2222_2222);
    chk("stall_release_ready", in_ready, 1);
    step();
    drive(0, 0, '0);
    step();
    step();
    chk("stall_final_count", order_count, 0);

    // Streaming on path 0 with the result mux popping every cycle
    out0_ready = 1'b1; out1_ready = 1'b0; order_pop = 1'b1;
    n_acc = 0; maxc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 32'hA000_0000 + 32'(i));
      chk("stream_in_ready", in_ready, 1);
      step();
      if (int'(order_count) > maxc) maxc = int'(order_count);
    end
    drive(0, 0, '0);
    step();
    chk("stream_accepts", n_acc, 8);
    chk("stream_max_count", maxc, 1);
    chk("stream_final_count", order_count, 0);

    // Fill the order FIFO, then push and pop on the same cycle
    out0_ready = 1'b1; out1_ready = 1'b1; order_pop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'(i), 32'h4000_0000 + 32'(i));
      chk("fill_in_ready", in_ready, 1);
      step();
    end
    chk("full_count", order_count, 4);
    drive(1, 1, 32'h5555_5555);
    chk("full_in_ready", in_ready, 0);
    step();
    chk("full_hold_count", order_count, 4);
    order_pop = 1'b1;
    #1;
    chk("full_pop_in_ready", in_ready, 1);
    step();
    chk("full_pushpop_count", order_count, 4);
    drive(0, 0, '0);
    repeat (4) step();
    chk("full_drained_count", order_count, 0);
    order_pop = 1'b0;

    // Reset in the middle of traffic
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1, 0, 32'h6666_6666);
    step();
    drive(1, 1, 32'h7777_7777);
    step();
    out0_ready = 1'b1;
    drive(1, 0, 32'h8888_8888);
    chk("pre_rst_in_ready", in_ready, 1);
    step();
    out0_ready = 1'b0;
    drive(0, 0, '0);
    chk("pre_rst_out0_valid", out0_valid, 1);
    chk("pre_rst_out1_valid", out1_valid, 1);
    chk("pre_rst_count", order_count, 3);
    reset = 1'b1;
    q0.delete(); q1.delete(); qo.delete();
    out1_ready = 1'b1; order_pop = 1'b1;
    drive(1, 1, 32'hDEAD_BEEF);
    step();
    reset = 1'b0;
    out1_ready = 1'b0; order_pop = 1'b0;
    drive(0, 0, '0);
    chk("mid_rst_out0_valid", out0_valid, 0);
    chk("mid_rst_out1_valid", out1_valid, 0);
    chk("mid_rst_out0_data", out0_data, 0);
    chk("mid_rst_out1_data", out1_data, 0);
    chk("mid_rst_count", order_count, 0);
    chk("mid_rst_order_valid", order_valid, 0);
    chk("mid_rst_order_sel", order_sel, 0);

    // Traffic resumes cleanly after reset
    out1_ready = 1'b1; order_pop = 1'b1;
    drive(1, 1, 32'h9999_0001);
    step();
    drive(0, 0, '0);
    chk("post_rst_out1_data", out1_data, 32'h9999_0001);
    chk("post_rst_order_sel", order_sel, 1);
    step();
    chk("post_rst_count", order_count, 0);
    chk("sb_leftover", q0.size() + q1.size() + qo.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
